// File: rtl/nco_clock_div_multi.sv
// Multi-channel phase-accumulator clock divider. Step and duty changes are
// staged in shadow registers and only take effect at the channel's wrap or on sync_clr.
module nco_clock_div_multi #(
  parameter int ACC_W     = 32,
  parameter int NUM_CH    = 4,
  parameter int DEFAULT_K = 86,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLOCK,
  input  logic              RST_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_clr,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_sel,
  input  logic [ACC_W-1:0]  cfg_data,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] cfg_pending
);

  localparam logic [ACC_W-1:0] K_RST    = ACC_W'(DEFAULT_K);
  localparam logic [ACC_W-1:0] DUTY_RST = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [1:0]       SEL_STEP  = 2'd0;
  localparam logic [1:0]       SEL_DUTY  = 2'd1;
  localparam logic [1:0]       SEL_PHASE = 2'd2;

  logic [ACC_W-1:0] acc_q      [NUM_CH];
  logic [ACC_W-1:0] step_act_q [NUM_CH];
  logic [ACC_W-1:0] step_sh_q  [NUM_CH];
  logic [ACC_W-1:0] duty_act_q [NUM_CH];
  logic [ACC_W-1:0] duty_sh_q  [NUM_CH];
  logic [ACC_W-1:0] phase_q    [NUM_CH];
  logic [NUM_CH-1:0] clk_q, tick_q, pend_q;

  logic [ACC_W-1:0] acc_d      [NUM_CH];
  logic [ACC_W-1:0] step_act_d [NUM_CH];
  logic [ACC_W-1:0] step_sh_d  [NUM_CH];
  logic [ACC_W-1:0] duty_act_d [NUM_CH];
  logic [ACC_W-1:0] duty_sh_d  [NUM_CH];
  logic [ACC_W-1:0] phase_d    [NUM_CH];
  logic [NUM_CH-1:0] clk_d, tick_d, pend_d;

  logic [ACC_W:0]    sum_s       [NUM_CH];
  logic [ACC_W-1:0]  step_eff_s  [NUM_CH];
  logic [ACC_W-1:0]  duty_eff_s  [NUM_CH];
  logic [ACC_W-1:0]  phase_eff_s [NUM_CH];
  logic [NUM_CH-1:0] wrap_s, wr_step_s, wr_duty_s, wr_phase_s;

  // Write decode; channel numbers at or above NUM_CH match no channel and are dropped.
  always_comb begin
    wr_step_s  = {NUM_CH{1'b0}};
    wr_duty_s  = {NUM_CH{1'b0}};
    wr_phase_s = {NUM_CH{1'b0}};
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (cfg_wr && (int'(cfg_ch) == ch)) begin
        case (cfg_sel)
          SEL_STEP:  wr_step_s[ch]  = 1'b1;
          SEL_DUTY:  wr_duty_s[ch]  = 1'b1;
          SEL_PHASE: wr_phase_s[ch] = 1'b1;
          default:   wr_step_s[ch]  = 1'b0;
        endcase
      end else begin
        wr_step_s[ch] = 1'b0;
      end
    end
  end

  // Per-channel next state; same-cycle writes are bypassed into any load/transfer.
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      step_eff_s[ch]  = wr_step_s[ch]  ? cfg_data : step_sh_q[ch];
      duty_eff_s[ch]  = wr_duty_s[ch]  ? cfg_data : duty_sh_q[ch];
      phase_eff_s[ch] = wr_phase_s[ch] ? cfg_data : phase_q[ch];
      sum_s[ch]       = {1'b0, acc_q[ch]} + {1'b0, step_act_q[ch]};
      wrap_s[ch]      = ch_en[ch] & sum_s[ch][ACC_W];

      step_sh_d[ch]  = step_eff_s[ch];
      duty_sh_d[ch]  = duty_eff_s[ch];
      phase_d[ch]    = phase_eff_s[ch];
      acc_d[ch]      = acc_q[ch];
      step_act_d[ch] = step_act_q[ch];
      duty_act_d[ch] = duty_act_q[ch];
      pend_d[ch]     = pend_q[ch] | wr_step_s[ch] | wr_duty_s[ch];
      tick_d[ch]     = 1'b0;
      clk_d[ch]      = clk_q[ch];

      if (sync_clr) begin
        acc_d[ch]      = phase_eff_s[ch];
        step_act_d[ch] = step_eff_s[ch];
        duty_act_d[ch] = duty_eff_s[ch];
        pend_d[ch]     = 1'b0;
        clk_d[ch]      = (phase_eff_s[ch] >= duty_eff_s[ch]);
      end else if (ch_en[ch]) begin
        acc_d[ch]  = sum_s[ch][ACC_W-1:0];
        tick_d[ch] = wrap_s[ch];
        if (wrap_s[ch] && pend_d[ch]) begin
          step_act_d[ch] = step_eff_s[ch];
          duty_act_d[ch] = duty_eff_s[ch];
          pend_d[ch]     = 1'b0;
        end else begin
          step_act_d[ch] = step_act_q[ch];
          duty_act_d[ch] = duty_act_q[ch];
        end
        clk_d[ch] = (acc_d[ch] >= duty_act_d[ch]);
      end else begin
        tick_d[ch] = 1'b0;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        acc_q[ch]      <= {ACC_W{1'b0}};
        step_act_q[ch] <= K_RST;
        step_sh_q[ch]  <= K_RST;
        duty_act_q[ch] <= DUTY_RST;
        duty_sh_q[ch]  <= DUTY_RST;
        phase_q[ch]    <= {ACC_W{1'b0}};
      end
      clk_q  <= {NUM_CH{1'b0}};
      tick_q <= {NUM_CH{1'b0}};
      pend_q <= {NUM_CH{1'b0}};
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        acc_q[ch]      <= acc_d[ch];
        step_act_q[ch] <= step_act_d[ch];
        step_sh_q[ch]  <= step_sh_d[ch];
        duty_act_q[ch] <= duty_act_d[ch];
        duty_sh_q[ch]  <= duty_sh_d[ch];
        phase_q[ch]    <= phase_d[ch];
      end
      clk_q  <= clk_d;
      tick_q <= tick_d;
      pend_q <= pend_d;
    end
  end

  assign clk_out     = clk_q;
  assign tick        = tick_q;
  assign cfg_pending = pend_q;

endmodule
